// File: rtl/des_seq_pkg.sv
// Shared types and helpers for the DES block sequencer: FSM states, block width
// and the per-block chaining mode captured at accept.
package des_seq_pkg;

    localparam int DES_BLOCK_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic cbc;
        logic decrypt;
    } seq_mode_t;

    // Conditional XOR used for both the pre-core and post-core chaining paths.
    function automatic logic [DES_BLOCK_W-1:0] xor_if(
        input logic                   en,
        input logic [DES_BLOCK_W-1:0] a,
        input logic [DES_BLOCK_W-1:0] b
    );
        xor_if = en ? (a ^ b) : a;
    endfunction

endpackage

// File: rtl/des_cbc_chain.sv
// CBC chaining datapath: chain register, pre-core XOR for CBC encrypt,
// post-core XOR for CBC decrypt, and IV load / per-block chain update.
import des_seq_pkg::*;

module des_cbc_chain (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DES_BLOCK_W-1:0] iv,
    input  seq_mode_t              accept_mode,
    input  logic [DES_BLOCK_W-1:0] blk_in,
    input  logic                   update,
    input  seq_mode_t              mode,
    input  logic [DES_BLOCK_W-1:0] blk,
    input  logic [DES_BLOCK_W-1:0] core_result,
    output logic [DES_BLOCK_W-1:0] pre_data,
    output logic [DES_BLOCK_W-1:0] post_data
);

    logic [DES_BLOCK_W-1:0] chain_r;
    logic [DES_BLOCK_W-1:0] chain_eff_s;

    // An IV loaded in the accept cycle must already apply to the block being accepted.
    always_comb begin
        chain_eff_s = load ? iv : chain_r;
        pre_data    = xor_if(accept_mode.cbc & ~accept_mode.decrypt, blk_in, chain_eff_s);
        post_data   = xor_if(mode.cbc & mode.decrypt, core_result, chain_r);
    end

    // Chain register: IV load in IDLE, ciphertext feedback on block completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {DES_BLOCK_W{1'b0}};
        end else if (load) begin
            chain_r <= iv;
        end else if (update && mode.cbc) begin
            chain_r <= mode.decrypt ? blk : core_result;
        end else begin
            chain_r <= chain_r;
        end
    end

endmodule

// File: rtl/des_block_sequencer.sv
// Initiator front end for DES_core: stream handshakes, one-cycle core command,
// completion wait with watchdog, and ECB/CBC chaining via des_cbc_chain.
import des_seq_pkg::*;

module des_block_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DES_BLOCK_W-1:0] cfg_key,
    input  logic [DES_BLOCK_W-1:0] cfg_iv,
    input  logic                   cfg_cbc,
    input  logic                   cfg_decrypt,
    input  logic                   cfg_load,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DES_BLOCK_W-1:0] out_data,
    output logic                   des_encipher_en,
    output logic                   des_decipher_en,
    output logic [DES_BLOCK_W-1:0] des_data,
    output logic [DES_BLOCK_W-1:0] des_key_in,
    input  logic                   desc_ready,
    input  logic [DES_BLOCK_W-1:0] desc_result,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    seq_state_t             state_r, state_s;
    seq_mode_t              mode_r, mode_in_s;
    logic [DES_BLOCK_W-1:0] blk_r, key_r, des_data_r, result_r;
    logic [DES_BLOCK_W-1:0] pre_s, post_s;
    logic [WD_W-1:0]        wd_r;
    logic                   in_ready_r, out_valid_r, busy_r, timeout_r;
    logic                   enc_r, dec_r;
    logic                   accept_s, load_s, done_s, expire_s;

    // Handshake qualifiers; desc_ready only counts while waiting on the core.
    always_comb begin
        mode_in_s.cbc     = cfg_cbc;
        mode_in_s.decrypt = cfg_decrypt;
        accept_s = (state_r == IDLE) && in_ready_r && in_valid;
        load_s   = (state_r == IDLE) && cfg_load;
        done_s   = (state_r == WAIT) && desc_ready;
        expire_s = (state_r == WAIT) && !desc_ready && (wd_r == WD_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? ISSUE : IDLE;
            ISSUE:   state_s = WAIT;
            WAIT: begin
                if (done_s) begin
                    state_s = OUT;
                end else if (expire_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            OUT:     state_s = out_ready ? IDLE : OUT;
            default: state_s = IDLE;
        endcase
    end

    // State and registered outputs; the command pulse and core operands are
    // loaded on the accept edge so they are valid throughout the ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            mode_r      <= '0;
            blk_r       <= {DES_BLOCK_W{1'b0}};
            key_r       <= {DES_BLOCK_W{1'b0}};
            des_data_r  <= {DES_BLOCK_W{1'b0}};
            result_r    <= {DES_BLOCK_W{1'b0}};
            wd_r        <= {WD_W{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            enc_r       <= 1'b0;
            dec_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == OUT);
            busy_r      <= (state_s != IDLE);
            enc_r       <= accept_s && !cfg_decrypt;
            dec_r       <= accept_s && cfg_decrypt;
            if (accept_s) begin
                blk_r      <= in_data;
                key_r      <= cfg_key;
                mode_r     <= mode_in_s;
                des_data_r <= pre_s;
            end
            if (state_r == ISSUE) begin
                wd_r <= {WD_W{1'b0}};
            end else if (state_r == WAIT) begin
                wd_r <= wd_r + WD_W'(1);
            end
            if (done_s) begin
                result_r <= post_s;
            end
            if (load_s) begin
                timeout_r <= 1'b0;
            end else if (expire_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    des_cbc_chain u_chain (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .iv          (cfg_iv),
        .accept_mode (mode_in_s),
        .blk_in      (in_data),
        .update      (done_s),
        .mode        (mode_r),
        .blk         (blk_r),
        .core_result (desc_result),
        .pre_data    (pre_s),
        .post_data   (post_s)
    );

    assign in_ready        = in_ready_r;
    assign out_valid       = out_valid_r;
    assign out_data        = result_r;
    assign des_encipher_en = enc_r;
    assign des_decipher_en = dec_r;
    assign des_data        = des_data_r;
    assign des_key_in      = key_r;
    assign busy            = busy_r;
    assign timeout_err     = timeout_r;

endmodule

// File: tb/tb_des_block_sequencer.sv
// Directed bench for des_block_sequencer with a DES_core stub that knows the
// reference DES vectors and otherwise applies a fixed XOR mask.
module tb_des_block_sequencer;

    localparam int CORE_LAT = 3;
    localparam logic [63:0] K  = 64'h133457799BBCDFF1;
    localparam logic [63:0] P  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C  = 64'h85E813540F0AB405;
    localparam logic [63:0] P2 = 64'h84CB563386A179EA;
    localparam logic [63:0] M  = 64'h5A5A5A5A5A5A5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] cfg_key = 64'd0, cfg_iv = 64'd0, in_data = 64'd0;
    logic        cfg_cbc = 1'b0, cfg_decrypt = 1'b0, cfg_load = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, des_encipher_en, des_decipher_en, busy, timeout_err;
    logic [63:0] out_data, des_data, des_key_in;
    logic        desc_ready = 1'b0;
    logic [63:0] desc_result = 64'd0;

    int checks = 0;
    int errors = 0;

    des_block_sequencer #(.TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_cbc(cfg_cbc),
        .cfg_decrypt(cfg_decrypt), .cfg_load(cfg_load), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .des_encipher_en(des_encipher_en), .des_decipher_en(des_decipher_en),
        .des_data(des_data), .des_key_in(des_key_in), .desc_ready(desc_ready),
        .desc_result(desc_result), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Core stub: fixed latency, table lookup of the reference DES vectors.
    int          stub_cnt = 0, enc_cnt = 0, dec_cnt = 0, rdy_cnt = 0;
    logic        hang = 1'b0;
    logic [63:0] stub_res = 64'd0;

    function automatic logic [63:0] stub_fn(input logic enc, input logic [63:0] d, input logic [63:0] k);
        if (enc) stub_fn = (d == P && k == K) ? C : (d ^ M);
        else     stub_fn = (d == C && k == K) ? P : (d ^ M);
    endfunction

    always @(posedge clk) begin
        desc_ready <= 1'b0;
        if (des_encipher_en) enc_cnt <= enc_cnt + 1;
        if (des_decipher_en) dec_cnt <= dec_cnt + 1;
        if (stub_cnt == 1) begin
            desc_ready  <= 1'b1;
            desc_result <= stub_res;
            rdy_cnt     <= rdy_cnt + 1;
        end
        if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
        if ((des_encipher_en || des_decipher_en) && !hang) begin
            stub_cnt <= CORE_LAT - 1;
            stub_res <= stub_fn(des_encipher_en, des_data, des_key_in);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one block and return just after the accept edge (ISSUE cycle).
    task automatic send(input logic [63:0] key, input logic [63:0] data, input logic cbc,
                        input logic dec, input logic load, input logic [63:0] iv);
        int n = 0;
        @(negedge clk);
        cfg_key = key; in_data = data; cfg_cbc = cbc; cfg_decrypt = dec;
        cfg_load = load; cfg_iv = iv; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
    endtask

    // Wait for out_valid; n counts negedges after the ISSUE-cycle negedge.
    task automatic collect(input logic [63:0] exp, input string name, output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid never rose", name);
        end else begin
            check(name, out_data, exp);
        end
    endtask

    typedef struct {
        logic [63:0] key, data;
        logic        cbc, dec, load;
        logic [63:0] iv, exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int   lat, e0, d0, r0;
        logic ov_seen;

        vecs[0] = '{K, P,            1'b0, 1'b0, 1'b0, 64'd0, C,  "ecb_enc"};
        vecs[1] = '{K, C,            1'b0, 1'b1, 1'b0, 64'd0, P,  "ecb_dec"};
        vecs[2] = '{K, P,            1'b1, 1'b0, 1'b1, 64'd0, C,  "cbc_enc_b0"};
        vecs[3] = '{K, P2,           1'b1, 1'b0, 1'b0, 64'd0, C,  "cbc_enc_b1"};
        vecs[4] = '{K, C,            1'b1, 1'b1, 1'b1, 64'd0, P,  "cbc_dec_b0"};
        vecs[5] = '{K, C,            1'b1, 1'b1, 1'b0, 64'd0, P2, "cbc_dec_b1"};
        vecs[6] = '{K, 64'd0,        1'b1, 1'b0, 1'b1, P,     C,  "cbc_enc_iv"};
        vecs[7] = '{K, 64'd1,        1'b0, 1'b0, 1'b0, 64'd0, 64'h5A5A5A5A5A5A5A5B, "ecb_enc_mask"};
        vecs[8] = '{K, 64'h5A5A5A5A5A5A5A5B, 1'b0, 1'b1, 1'b0, 64'd0, 64'd1, "ecb_dec_mask"};
        vecs[9] = '{K, P2,           1'b1, 1'b0, 1'b0, 64'd0, C,  "cbc_after_ecb"};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outs", {in_ready, out_valid, des_encipher_en, des_decipher_en, busy, timeout_err},
              64'd0);
        check("rst_data", des_data | des_key_in | out_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 10; i++) begin
            e0 = enc_cnt;
            d0 = dec_cnt;
            send(vecs[i].key, vecs[i].data, vecs[i].cbc, vecs[i].dec, vecs[i].load, vecs[i].iv);
            collect(vecs[i].exp, vecs[i].name, lat);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(CORE_LAT + 1));
            @(posedge clk);
            #1;
            check({vecs[i].name, "_enc_pulses"}, 64'(enc_cnt - e0), {63'd0, ~vecs[i].dec});
            check({vecs[i].name, "_dec_pulses"}, 64'(dec_cnt - d0), {63'd0, vecs[i].dec});
        end

        // Backpressure: result held, no accept, no core command while stalled.
        out_ready = 1'b0;
        send(K, P, 1'b0, 1'b0, 1'b0, 64'd0);
        collect(C, "bp_first", lat);
        e0 = enc_cnt + dec_cnt;
        in_valid = 1'b1;
        in_data  = P2;
        repeat (10) begin
            @(negedge clk);
            check("bp_out_data", out_data, C);
            check("bp_hold", {62'd0, out_valid, in_ready}, 64'd2);
        end
        check("bp_no_cmd", 64'(enc_cnt + dec_cnt - e0), 64'd0);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp_release", {61'd0, in_ready, out_valid, busy}, 64'd4);

        // Watchdog: stub never answers.
        hang = 1'b1;
        send(K, P, 1'b0, 1'b0, 1'b0, 64'd0);
        @(negedge clk);
        check("to_issue_pulse", {63'd0, des_encipher_en}, 64'd1);
        ov_seen = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
            if (k == 32) check("to_before", {62'd0, timeout_err, in_ready}, 64'd0);
            if (k == 33) check("to_after", {61'd0, timeout_err, in_ready, busy}, 64'd6);
        end
        check("to_no_out", {63'd0, ov_seen}, 64'd0);
        cfg_iv   = 64'd0;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        check("to_cleared", {63'd0, timeout_err}, 64'd0);
        hang = 1'b0;

        // Reset in WAIT: async clear, late desc_ready ignored, next block fine.
        r0 = rdy_cnt;
        send(K, P, 1'b0, 1'b0, 1'b0, 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstw_outs", {in_ready, out_valid, des_encipher_en, des_decipher_en, busy}, 64'd0);
        check("rstw_data", des_data | des_key_in, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || busy) ov_seen = 1'b1;
        end
        check("rstw_core_fired", 64'(rdy_cnt - r0), 64'd1);
        check("rstw_ignored", {63'd0, ov_seen}, 64'd0);
        send(K, P, 1'b0, 1'b0, 1'b0, 64'd0);
        collect(C, "rstw_next_block", lat);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_block_sequencer.md
Name: des_block_sequencer

Overview:
- Initiator-side front end for DES_core.
- Accepts 64-bit blocks on a valid/ready stream and issues encipher/decipher commands to the core, then waits for desc_ready and returns results on an output valid/ready stream.
- Adds ECB/CBC chaining so software streams multi-block messages without per-block IV handling.
- Sits between the host datapath and DES_core; owns des_encipher_en, des_decipher_en, des_data and des_key_in.

Parameters:
- TIMEOUT_CYCLES, 64: cycles allowed in WAIT for desc_ready before aborting the block.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_key  in  64  DES key, sampled at block accept
- cfg_iv  in  64  CBC initial vector
- cfg_cbc  in  1  0=ECB, 1=CBC, sampled at block accept
- cfg_decrypt  in  1  0=encrypt, 1=decrypt, sampled at block accept
- cfg_load  in  1  pulse; loads cfg_iv into chain register, clears timeout_err
- in_valid  in  1  input block valid
- in_ready  out  1  sequencer can accept a block
- in_data  in  64  plaintext (encrypt) or ciphertext (decrypt)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  64  result block
- des_encipher_en  out  1  one-cycle encipher command to core
- des_decipher_en  out  1  one-cycle decipher command to core
- des_data  out  64  block to core
- des_key_in  out  64  key to core
- desc_ready  in  1  core completion pulse; desc_result valid same cycle
- desc_result  in  64  core output
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky; set on watchdog expiry

Behaviour:
- Reset: all outputs 0, state IDLE, chain/blk/key/result registers 0, watchdog 0.
- Reset mid-operation returns to IDLE immediately; enables drop asynchronously; in-flight block is lost.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: blk_reg<=in_data, key_reg<=cfg_key, latch cfg_cbc/cfg_decrypt; go ISSUE.
- ISSUE, exactly 1 cycle:
  - Pulse des_encipher_en (encrypt) or des_decipher_en (decrypt); never both.
  - des_data = blk_reg ^ chain for CBC encrypt; blk_reg otherwise. Registered into des_data_reg, held through WAIT.
  - Watchdog<=0; go WAIT.
- WAIT:
  - des_data and des_key_in stay stable; watchdog increments.
  - On desc_ready: result_reg = desc_result ^ chain for CBC decrypt, else desc_result.
  - Chain update on the same edge: CBC encrypt chain<=desc_result; CBC decrypt chain<=blk_reg; ECB leaves chain unchanged.
  - Then go OUT.
  - If watchdog == TIMEOUT_CYCLES-1 with no desc_ready: timeout_err<=1, chain unchanged, no output, go IDLE.
  - desc_ready on the expiry cycle takes priority; the block completes normally.
- OUT:
  - out_valid=1; out_data=result_reg stable until out_ready.
  - On out_ready go IDLE; in_ready=0 throughout OUT.
- desc_ready in IDLE, ISSUE or OUT is ignored.
- cfg_load:
  - Honoured only in IDLE; ignored elsewhere.
  - With in_valid in the same IDLE cycle, the new IV applies to the accepted block.
- Latency, accept to out_valid: 2 + core latency cycles. Throughput: one block per (3 + core latency) cycles with out_ready=1.
- Watchdog width: $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Package des_seq_pkg:
  - state enum {IDLE, ISSUE, WAIT, OUT};
  - DES_BLOCK_W=64 constant;
  - mode typedef struct {cbc, decrypt}.
- Sub-module des_cbc_chain: holds the chain register, the pre-core XOR mux, the post-core XOR mux, and the load/update logic. The FSM and handshakes stay in the top.

Test Plan:
- ECB encrypt: key 133457799BBCDFF1, in_data 0123456789ABCDEF -> out_data 85E813540F0AB405, exactly one des_encipher_en pulse, des_decipher_en never high.
- ECB decrypt, same key: in_data 85E813540F0AB405 -> 0123456789ABCDEF.
- CBC encrypt, IV 0 loaded, blocks 0123456789ABCDEF then 84CB563386A179EA:
  - outputs 85E813540F0AB405 then 85E813540F0AB405.
  - CBC decrypt of those two ciphertexts, IV 0, returns both plaintexts.
- Backpressure: out_ready low 10 cycles after out_valid -> out_data constant, in_ready 0, no new core command; release -> IDLE next cycle.
- Timeout with TIMEOUT_CYCLES=32 and a core stub that never asserts desc_ready:
  - timeout_err rises 32 cycles after the ISSUE cycle, in_ready returns, out_valid never asserted.
  - cfg_load clears timeout_err.
- Reset asserted in WAIT: outputs 0 asynchronously; a later desc_ready is ignored; the next block after reset encrypts correctly.
